apu_reg_file: RTL and testbench

- Parametrised successor to the APU memory-mapped register bank.
- Decodes CPU accesses against a configurable base and depth; out-of-window accesses are ignored.
- Stores write-only channel registers and emits per-register write strobes.
- Adds a readable status register with a frame-IRQ flag that clears on read, open-bus read data, and a combined APU IRQ output.

---
 rtl/apu_pkg.sv | 54 +++++
 rtl/apu_status_reg.sv | 37 +++
 rtl/apu_reg_file.sv | 115 +++++++++++
 tb/tb_apu_reg_file.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared constants for the APU register bank: register indices within the
// $4000 window, status-byte bit positions and the frame-counter inhibit bit.
package apu_pkg;

  // Register indices relative to $4000
  localparam int APU_PULSE1_CTRL  = 0;
  localparam int APU_PULSE1_SWEEP = 1;
  localparam int APU_PULSE1_TLO   = 2;
  localparam int APU_PULSE1_THI   = 3;
  localparam int APU_PULSE2_CTRL  = 4;
  localparam int APU_PULSE2_SWEEP = 5;
  localparam int APU_PULSE2_TLO   = 6;
  localparam int APU_PULSE2_THI   = 7;
  localparam int APU_TRI_CTRL     = 8;
  localparam int APU_TRI_TLO      = 10;
  localparam int APU_TRI_THI      = 11;
  localparam int APU_NOISE_CTRL   = 12;
  localparam int APU_NOISE_PERIOD = 14;
  localparam int APU_NOISE_LEN    = 15;
  localparam int APU_DMC_CTRL     = 16;
  localparam int APU_DMC_LOAD     = 17;
  localparam int APU_DMC_ADDR     = 18;
  localparam int APU_DMC_LEN      = 19;
  localparam int APU_OAM_DMA      = 20;
  localparam int APU_STATUS       = 21;
  localparam int APU_JOY1         = 22;
  localparam int APU_FRAME        = 23;

  // Status byte ($4015 read) bit positions
  localparam int STAT_DMC_IRQ   = 7;
  localparam int STAT_FRAME_IRQ = 6;
  localparam int STAT_OPEN_BUS  = 5;
  localparam int STAT_DMC_ACT   = 4;

  // Frame-counter register ($4017) IRQ inhibit bit
  localparam int FRAME_IRQ_INHIBIT_BIT = 6;

  // Assemble the status byte from its individual sources.
  function automatic logic [7:0] make_status(input logic       dmc_irq,
                                             input logic       frame_irq,
                                             input logic       open_bus_b5,
                                             input logic       dmc_active,
                                             input logic [3:0] len_nonzero);
    logic [7:0] s;
    s                 = 8'h00;
    s[3:0]            = len_nonzero;
    s[STAT_DMC_ACT]   = dmc_active;
    s[STAT_OPEN_BUS]  = open_bus_b5;
    s[STAT_FRAME_IRQ] = frame_irq;
    s[STAT_DMC_IRQ]   = dmc_irq;
    return s;
  endfunction

endpackage

// File: rtl/apu_status_reg.sv
// Frame-IRQ flag with set-beats-clear priority, plus status byte assembly.
// The returned status byte reflects the flag value before this cycle's update.
module apu_status_reg
  import apu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_l,
  input  logic       cpu_clk_en,
  input  logic       frame_irq_set,
  input  logic       status_rd,
  input  logic       inhibit_wr,
  input  logic       dmc_irq,
  input  logic       dmc_active,
  input  logic [3:0] len_nonzero,
  input  logic       open_bus_b5,
  output logic       frame_irq_flag,
  output logic [7:0] status_byte
);

  // Frame IRQ flag: set has priority over read-clear and inhibit-clear.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      frame_irq_flag <= 1'b0;
    end else if (cpu_clk_en) begin
      if (frame_irq_set)
        frame_irq_flag <= 1'b1;
      else if (status_rd || inhibit_wr)
        frame_irq_flag <= 1'b0;
    end
  end

  assign status_byte = make_status(dmc_irq, frame_irq_flag, open_bus_b5,
                                   dmc_active, len_nonzero);

endmodule

// File: rtl/apu_reg_file.sv
// APU memory-mapped register bank: window decode, write-only channel
// registers with per-register strobes, open-bus reads and $4015 status.
// Optional macro APU_REG_READBACK_EN: non-status reads return the stored
// register instead of the open-bus value.
module apu_reg_file
  import apu_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h4000,
  parameter int          NUM_REGS   = 24,
  parameter int          STATUS_IDX = APU_STATUS,
  parameter int          FRAME_IDX  = APU_FRAME,
  parameter int          IDX_W      = 5
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     cpu_clk_en,
  input  logic [15:0]              reg_addr,
  input  logic [7:0]               reg_data_in,
  input  logic                     reg_en,
  input  logic                     reg_we,
  input  logic [3:0]               len_nonzero,
  input  logic                     dmc_active,
  input  logic                     dmc_irq,
  input  logic                     frame_irq_set,
  output logic [7:0]               reg_data_out,
  output logic [NUM_REGS-1:0]      reg_updates,
  output logic [NUM_REGS-1:0][7:0] reg_array,
  output logic                     irq_l
);

  // 17-bit bounds so BASE_ADDR + NUM_REGS cannot wrap past $FFFF
  localparam logic [16:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [16:0] WIN_HI = WIN_LO + 17'(NUM_REGS);

  logic             hit;
  logic [IDX_W-1:0] idx;
  logic             wr_hit;
  logic             rd_hit;
  logic             status_rd;
  logic             inhibit_wr;
  logic [7:0]       open_bus;
  logic [7:0]       status_byte;
  logic [7:0]       rd_data;
  logic             frame_irq_flag;

  assign hit    = reg_en && ({1'b0, reg_addr} >= WIN_LO) && ({1'b0, reg_addr} < WIN_HI);
  assign idx    = IDX_W'(reg_addr - BASE_ADDR);
  assign wr_hit = hit && reg_we;
  assign rd_hit = hit && !reg_we;

  assign status_rd  = rd_hit && (idx == IDX_W'(STATUS_IDX));
  assign inhibit_wr = wr_hit && (idx == IDX_W'(FRAME_IDX)) &&
                      reg_data_in[FRAME_IRQ_INHIBIT_BIT];

  apu_status_reg u_status (
    .clk            (clk),
    .rst_l          (rst_l),
    .cpu_clk_en     (cpu_clk_en),
    .frame_irq_set  (frame_irq_set),
    .status_rd      (status_rd),
    .inhibit_wr     (inhibit_wr),
    .dmc_irq        (dmc_irq),
    .dmc_active     (dmc_active),
    .len_nonzero    (len_nonzero),
    .open_bus_b5    (open_bus[STAT_OPEN_BUS]),
    .frame_irq_flag (frame_irq_flag),
    .status_byte    (status_byte)
  );

  // Read-data source for non-status registers.
  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
`ifdef APU_REG_READBACK_EN
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_REGS; i++)
      if (idx == IDX_W'(i)) rd_data = reg_array[i];
  end
`else
  always_comb begin
    rd_data = open_bus;
  end
`endif

  // Register storage, write strobes and open-bus latch.
  // NOTE: the register array is reset because it drives channel state
  // directly; it is small flop storage, not a RAM macro.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      reg_array   <= '0;
      reg_updates <= '0;
      open_bus    <= 8'h00;
    end else if (cpu_clk_en) begin
      reg_updates <= '0;
      if (wr_hit) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (idx == IDX_W'(i)) reg_array[i] <= reg_data_in;
        reg_updates <= NUM_REGS'(1) << idx;
        open_bus    <= reg_data_in;
      end
    end
  end

  // Registered read data; holds on non-hit and write cycles.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      reg_data_out <= 8'h00;
    end else if (cpu_clk_en && rd_hit) begin
      reg_data_out <= status_rd ? status_byte : rd_data;
    end
  end

  assign irq_l = ~(frame_irq_flag | dmc_irq);

endmodule

// File: tb/tb_apu_reg_file.sv
// Directed self-checking bench for apu_reg_file.
module tb_apu_reg_file;

  logic            clk = 1'b0;
  logic            rst_l;
  logic            cpu_clk_en;
  logic [15:0]     reg_addr;
  logic [7:0]      reg_data_in;
  logic            reg_en;
  logic            reg_we;
  logic [3:0]      len_nonzero;
  logic            dmc_active;
  logic            dmc_irq;
  logic            frame_irq_set;
  logic [7:0]      reg_data_out;
  logic [23:0]     reg_updates;
  logic [23:0][7:0] reg_array;
  logic            irq_l;

  logic [23:0][7:0] exp_array;
  logic [7:0]       exp_rd;
  int total = 0;
  int bad   = 0;

  apu_reg_file dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .cpu_clk_en    (cpu_clk_en),
    .reg_addr      (reg_addr),
    .reg_data_in   (reg_data_in),
    .reg_en        (reg_en),
    .reg_we        (reg_we),
    .len_nonzero   (len_nonzero),
    .dmc_active    (dmc_active),
    .dmc_irq       (dmc_irq),
    .frame_irq_set (frame_irq_set),
    .reg_data_out  (reg_data_out),
    .reg_updates   (reg_updates),
    .reg_array     (reg_array),
    .irq_l         (irq_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive an access for one clock; returns at the following negedge.
  task automatic access(input logic we, input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    reg_en = 1'b1; reg_we = we; reg_addr = addr; reg_data_in = data;
    @(negedge clk);
    reg_en = 1'b0; reg_we = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    rst_l = 1'b0; cpu_clk_en = 1'b1; reg_addr = 16'h0; reg_data_in = 8'h0;
    reg_en = 1'b0; reg_we = 1'b0; len_nonzero = 4'h0; dmc_active = 1'b0;
    dmc_irq = 1'b0; frame_irq_set = 1'b0;
    exp_array = '0;

    // Reset state; irq_l follows dmc_irq alone
    #12;
    check("rst_array", reg_array, '0);
    check("rst_upd", 192'(reg_updates), 192'h0);
    check("rst_rdout", 192'(reg_data_out), 192'h0);
    check("rst_irq", 192'(irq_l), 192'h1);
    dmc_irq = 1'b1; #1;
    check("rst_irq_dmc", 192'(irq_l), 192'h0);
    dmc_irq = 1'b0;
    @(negedge clk); rst_l = 1'b1;

    // Write then asynchronous reset mid-cycle
    access(1'b1, 16'h4000, 8'hBF);
    check("bf_array0", 192'(reg_array[0]), 192'hBF);
    check("bf_upd", 192'(reg_updates), 192'h1);
    #2 rst_l = 1'b0; #1;
    check("async_array", reg_array, '0);
    check("async_upd", 192'(reg_updates), 192'h0);
    @(negedge clk); rst_l = 1'b1;

    // Write $4003 with enable: strobe for one enabled cycle
    access(1'b1, 16'h4003, 8'h5A);
    exp_array[3] = 8'h5A;
    check("w3_array", reg_array, exp_array);
    check("w3_upd", 192'(reg_updates), 192'h000008);
    idle();
    check("w3_upd_clr", 192'(reg_updates), 192'h0);

    // Same register, CPU enable low: nothing changes
    cpu_clk_en = 1'b0;
    access(1'b1, 16'h4003, 8'hA5);
    check("dis_array", reg_array, exp_array);
    check("dis_upd", 192'(reg_updates), 192'h0);
    cpu_clk_en = 1'b1;

    // Out-of-window writes just past each edge
    access(1'b1, 16'h4018, 8'hFF);
    check("oow_hi_upd", 192'(reg_updates), 192'h0);
    access(1'b1, 16'h3FFF, 8'hFF);
    check("oow_lo_upd", 192'(reg_updates), 192'h0);
    check("oow_array", reg_array, exp_array);

    // Frame IRQ pulse, status read clears it (open_bus = 5A, bit5 = 0)
    len_nonzero = 4'b1010; dmc_active = 1'b1;
    @(negedge clk); frame_irq_set = 1'b1;
    @(negedge clk); frame_irq_set = 1'b0;
    check("fset_irq", 192'(irq_l), 192'h0);
    access(1'b0, 16'h4015, 8'h00);
    check("stat_rd1", 192'(reg_data_out), 192'h5A);
    check("stat_irq1", 192'(irq_l), 192'h1);
    access(1'b0, 16'h4015, 8'h00);
    check("stat_rd2", 192'(reg_data_out), 192'h1A);

    // Set coinciding with status read: old value returned, flag stays set
    @(negedge clk);
    reg_en = 1'b1; reg_we = 1'b0; reg_addr = 16'h4015; frame_irq_set = 1'b1;
    @(negedge clk);
    reg_en = 1'b0; frame_irq_set = 1'b0;
    check("coinc_rd", 192'(reg_data_out), 192'h1A);
    check("coinc_irq", 192'(irq_l), 192'h0);

    // Inhibit write clears flag, then open-bus read of $4000
    access(1'b1, 16'h4017, 8'h40);
    exp_array[23] = 8'h40;
    check("inh_irq", 192'(irq_l), 192'h1);
    check("inh_upd", 192'(reg_updates), 192'h800000);
    access(1'b0, 16'h4000, 8'h00);
`ifdef APU_REG_READBACK_EN
    exp_rd = exp_array[0];
`else
    exp_rd = 8'h40;
`endif
    check("ob_rd", 192'(reg_data_out), 192'(exp_rd));

    // Status write sets open_bus bit5; dmc_irq reflected in bit7 and irq_l
    access(1'b1, 16'h4015, 8'h20);
    exp_array[21] = 8'h20;
    check("w15_array", reg_array, exp_array);
    access(1'b0, 16'h4015, 8'h00);
    check("stat_ob5", 192'(reg_data_out), 192'h3A);
    dmc_irq = 1'b1;
    access(1'b0, 16'h4015, 8'h00);
    check("stat_dmc", 192'(reg_data_out), 192'hBA);
    check("dmc_irq_l", 192'(irq_l), 192'h0);
    dmc_irq = 1'b0;

    // Non-hit read and disabled read hold reg_data_out
    access(1'b0, 16'h4018, 8'h00);
    check("nohit_hold", 192'(reg_data_out), 192'hBA);
    cpu_clk_en = 1'b0;
    access(1'b0, 16'h4000, 8'h00);
    check("dis_rd_hold", 192'(reg_data_out), 192'hBA);
    cpu_clk_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
